// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DATA} owner_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/access_timer.sv
// rtl/access_timer.sv - loadable saturating down-counter with zero flag
module access_timer
  import mem_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // load wins over dec; dec stops at zero so the streak budget saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= RST_VAL;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory between fetch and data ports
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WAIT_CYCLES  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_rd_req,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              freeze,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  owner_t owner;
  logic   cancel;
  logic   cnt_zero, budget_zero;
  logic   data_req, grant_if, grant_data;

  assign data_req   = d_rd_req | d_wr_req;
  // fetch wins only once data has used up its streak budget
  assign grant_if   = (state == IDLE) & if_req & ~if_flush & (~data_req | budget_zero);
  assign grant_data = (state == IDLE) & data_req & ~grant_if;

  access_timer #(.RST_VAL('0)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_if | grant_data),
    .load_val (CNT_W'(WAIT_CYCLES - 1)),
    .dec      (state == ACCESS),
    .zero     (cnt_zero)
  );

  // streak is tracked as remaining budget: zero means STARVE_LIMIT data grants in a row
  access_timer #(.RST_VAL(CNT_W'(STARVE_LIMIT))) u_streak (
    .clk      (clk),
    .rst      (rst),
    .load     (~if_req | grant_if),
    .load_val (CNT_W'(STARVE_LIMIT)),
    .dec      (grant_data),
    .zero     (budget_zero)
  );

  assign if_stall = if_req & ~if_ack & ~rst;
  assign freeze   = data_req & ~d_ack & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      cancel    <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          cancel <= 1'b0;
          if (grant_data) begin
            owner     <= OWN_DATA;
            mem_cs    <= 1'b1;
            mem_we    <= d_wr_req;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= ACCESS;
          end else if (grant_if) begin
            owner     <= OWN_IF;
            mem_cs    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (owner == OWN_IF && if_flush)
            cancel <= 1'b1;
          if (cnt_zero) begin
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
            state  <= RESP;
            // a flush in the last access cycle must also suppress the ack
            if (owner == OWN_IF) begin
              if_rdata <= mem_rdata;
              if_ack   <= ~(cancel | if_flush);
            end else begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end
          end
        end
        RESP: begin
          if (owner == OWN_IF && if_flush)
            cancel <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, d_rd_req, d_wr_req;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic        if_ack, if_stall, d_ack, freeze, mem_cs, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack_1, if_stall_1, d_ack_1, freeze_1, mem_cs_1, mem_we_1;
  logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return (a == 32'h10) ? 32'hE3A00001 : (a ^ 32'h5A5A0000);
  endfunction

  assign mem_rdata   = model_rd(mem_addr);
  assign mem_rdata_1 = model_rd(mem_addr_1);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2), .STARVE_LIMIT(2)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .freeze(freeze),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1), .STARVE_LIMIT(4)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack_1), .if_rdata(if_rdata_1), .if_stall(if_stall_1),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_1), .d_rdata(d_rdata_1), .freeze(freeze_1),
    .mem_cs(mem_cs_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] order [6];
  logic [1:0] exp_order [6];
  int n;

  initial begin
    rst = 1'b1; if_req = 0; if_flush = 0; d_rd_req = 0; d_wr_req = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    exp_order = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_mem_cs", mem_cs, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_freeze", freeze, 0);
    next_cycle();
    rst = 1'b0;

    // single fetch, WAIT_CYCLES=2
    if_req = 1; if_addr = 32'h10;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("t1_cs c%0d", c), mem_cs, (c == 1 || c == 2));
      check($sformatf("t1_ack c%0d", c), if_ack, (c == 3));
      check($sformatf("t1_stall c%0d", c), if_stall, (c <= 2));
      if (c == 1) check("t1_addr", mem_addr, 32'h10);
      if (c == 3) check("t1_rdata", if_rdata, 32'hE3A00001);
      next_cycle();
      if (c == 3) if_req = 0;
    end

    // simultaneous write and fetch: write first
    if_req = 1; if_addr = 32'h20; d_wr_req = 1; d_addr = 32'h400; d_wdata = 32'hDEADBEEF;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("t2_cs c%0d", c), mem_cs, (c == 1 || c == 2 || c == 5 || c == 6));
      check($sformatf("t2_we c%0d", c), mem_we, (c == 1 || c == 2));
      check($sformatf("t2_dack c%0d", c), d_ack, (c == 3));
      check($sformatf("t2_iack c%0d", c), if_ack, (c == 7));
      check($sformatf("t2_freeze c%0d", c), freeze, (c <= 2));
      check($sformatf("t2_stall c%0d", c), if_stall, (c <= 6));
      if (c == 1) begin
        check("t2_waddr", mem_addr, 32'h400);
        check("t2_wdata", mem_wdata, 32'hDEADBEEF);
      end
      if (c == 5) check("t2_faddr", mem_addr, 32'h20);
      if (c == 7) check("t2_rdata", if_rdata, 32'h5A5A0020);
      next_cycle();
      if (c == 3) d_wr_req = 0;
      if (c == 7) if_req = 0;
    end

    // starvation bound, STARVE_LIMIT=2
    for (int i = 0; i < 6; i++) order[i] = 2'd0;
    n = 0;
    d_rd_req = 1; d_addr = 32'h800; if_req = 1; if_addr = 32'h80;
    for (int c = 0; c < 30 && n < 6; c++) begin
      @(negedge clk);
      if (if_ack) begin order[n] = 2'd2; n++; end
      else if (d_ack) begin order[n] = 2'd1; n++; end
      if (n < 6) next_cycle();
    end
    for (int i = 0; i < 6; i++) check($sformatf("t3_order %0d", i), order[i], exp_order[i]);
    next_cycle();
    d_rd_req = 0; if_req = 0;
    next_cycle();

    // flush during fetch access
    if_req = 1; if_addr = 32'h30;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("t4_cs c%0d", c), mem_cs, (c == 1 || c == 2 || c == 5 || c == 6));
      check($sformatf("t4_ack c%0d", c), if_ack, (c == 7));
      if (c == 2) check("t4_addr_old", mem_addr, 32'h30);
      if (c == 5) check("t4_addr_new", mem_addr, 32'h44);
      if (c == 7) check("t4_rdata", if_rdata, 32'h5A5A0044);
      next_cycle();
      if_flush = (c == 0);
      if (c == 0) if_addr = 32'h44;
      if (c == 7) if_req = 0;
    end

    // async reset mid write
    d_wr_req = 1; d_addr = 32'h500; d_wdata = 32'h12345678;
    next_cycle();
    @(negedge clk);
    check("t5_cs_pre", mem_cs, 1);
    check("t5_we_pre", mem_we, 1);
    #2 rst = 1;
    #1;
    check("t5_cs_rst", mem_cs, 0);
    check("t5_we_rst", mem_we, 0);
    check("t5_dack_rst", d_ack, 0);
    check("t5_freeze_rst", freeze, 0);
    d_wr_req = 0;
    next_cycle();
    rst = 0;
    d_rd_req = 1; d_addr = 32'h600;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("t5_dack c%0d", c), d_ack, (c == 3));
      check($sformatf("t5_freeze c%0d", c), freeze, (c < 3));
      if (c == 3) check("t5_rdata", d_rdata, 32'h5A5A0600);
      next_cycle();
      if (c == 3) d_rd_req = 0;
    end

    // WAIT_CYCLES=1 back-to-back reads
    rst = 1;
    next_cycle();
    rst = 0;
    d_rd_req = 1; d_addr = 32'h700;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("t6_cs c%0d", c), mem_cs_1, (c % 3 == 1));
      check($sformatf("t6_ack c%0d", c), d_ack_1, (c % 3 == 2));
      if (c % 3 == 2) check($sformatf("t6_rdata c%0d", c), d_rdata_1, model_rd(32'h700 + 32'(4 * (c / 3))));
      next_cycle();
      if (c % 3 == 2) d_addr = d_addr + 32'h4;
      if (c == 8) d_rd_req = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, fixed-latency instruction/data memory between the fetch stage (read-only) and the memory stage (read/write). Requests are granted one at a time. The block sequences each multi-cycle access, returns read data with a one-cycle acknowledge, and raises pipeline-freeze indications while a requester waits. It sits between the IF/MEM stages and the external memory macro, below the top-level pipeline.

Parameters:
ADDR_W, 32, address width of both requester ports and the memory bus.
DATA_W, 32, data width.
WAIT_CYCLES, 4, cycles the memory bus must hold an access stable (legal range 1..15).
STARVE_LIMIT, 4, number of consecutive data grants allowed while a fetch is pending (legal range 1..15).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
if_req  in  1  fetch read request; held until if_ack.
if_addr  in  ADDR_W  fetch address; stable while if_req is high.
if_flush  in  1  branch taken; cancels a pending or in-flight fetch.
if_ack  out  1  one-cycle pulse; if_rdata is valid in that cycle.
if_rdata  out  DATA_W  fetched word.
if_stall  out  1  if_req & ~if_ack.
d_rd_req  in  1  data read request; held until d_ack.
d_wr_req  in  1  data write request; held until d_ack; never asserted together with d_rd_req.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  store value.
d_ack  out  1  one-cycle pulse; d_rdata is valid in that cycle for reads.
d_rdata  out  DATA_W  loaded word.
freeze  out  1  (d_rd_req | d_wr_req) & ~d_ack; freezes the whole pipeline.
mem_cs  out  1  memory select.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data; valid in the last ACCESS cycle.

Behaviour:
- Reset (async) sets the state to IDLE and clears owner, counter, streak counter and cancel flag. All outputs go to 0 immediately, so mem_cs drops at once. A write interrupted by reset may be partial; this is accepted.
- States are IDLE, ACCESS and RESP.
- IDLE, at each clock edge:
  - If a data request is present, grant DATA, unless streak == STARVE_LIMIT and if_req & ~if_flush, in which case grant IF.
  - Otherwise, if if_req & ~if_flush, grant IF.
  - A grant latches addr, wdata and we into registers, loads cnt = WAIT_CYCLES-1 and moves to ACCESS.
- ACCESS:
  - mem_cs = 1; mem_addr, mem_we and mem_wdata come from the latched registers and stay stable for all WAIT_CYCLES cycles.
  - When cnt == 0: capture mem_rdata into the owner's rdata register and move to RESP. Otherwise decrement cnt.
- RESP:
  - mem_cs = 0.
  - Pulse the owner's ack for one cycle, unless the owner is IF and the cancel flag is set; then no ack is given.
  - Return to IDLE.
- Latency: a request raised in cycle 0 while IDLE is acknowledged in cycle WAIT_CYCLES+1. Peak throughput is one access per WAIT_CYCLES+2 cycles. The requester drops its request after seeing ack, so the freshly re-entered IDLE cannot double-grant.
- Streak counter:
  - Increments on every DATA grant made while if_req is high.
  - Clears on any IF grant and whenever if_req is low.
  - Saturates at STARVE_LIMIT.
- if_flush:
  - In IDLE, it blocks an IF grant in that cycle.
  - While owner == IF in ACCESS or RESP, it sets the cancel flag, which clears in IDLE. The memory access still completes; only if_ack is suppressed.
  - It never affects data accesses.
- Simultaneous if_req and data request with streak < STARVE_LIMIT: DATA wins, and if_stall stays high.
- if_rdata and d_rdata hold their value until the next capture for the same owner.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - owner enum {OWN_IF, OWN_DATA};
  - counter width constant CNT_W = 4.
- One natural sub-module: access_timer. It is a loadable down-counter with a zero flag, used for both cnt and the bounded streak logic.
- The FSM, grant mux and output registers stay in mem_port_arbiter.

Test Plan:
- WAIT_CYCLES=2; if_req with addr 0x10 in cycle 0, memory returning 0xE3A00001 -> mem_cs high in cycles 1-2, if_ack with if_rdata=0xE3A00001 in cycle 3, if_stall high in cycles 0-2.
- if_req and d_wr_req (addr 0x400, data 0xDEADBEEF) together in cycle 0 -> write granted first (mem_we=1 in cycles 1-2, d_ack in cycle 3), then fetch granted, if_ack in cycle 7; freeze high in cycles 0-2 only.
- STARVE_LIMIT=2; continuous data reads plus if_req held -> grant order DATA, DATA, IF, DATA, DATA, IF.
- if_flush pulsed during the ACCESS of a fetch -> mem_cs still held WAIT_CYCLES cycles, no if_ack, next fetch (new address) granted normally.
- rst asserted mid-ACCESS of a write -> mem_cs, mem_we, d_ack and freeze all 0 without waiting for a clock edge; after release, a new d_rd_req completes in WAIT_CYCLES+1 cycles.
- WAIT_CYCLES=1 boundary: back-to-back data reads -> ack every 3 cycles, mem_rdata captured from the single ACCESS cycle.
